// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, coordinate type and segment arithmetic
// used by the VGA scan generator and its counters.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    typedef logic [9:0] coord_t;

    function automatic int seg_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    function automatic int sync_start(input int vis, input int front);
        return vis + front;
    endfunction

    function automatic int sync_end(input int vis, input int front, input int sync);
        return vis + front + sync;
    endfunction

endpackage

// File: rtl/vga_scan_gen_scan_counter.sv
// Modulo-MOD coordinate counter that advances on en; wrap flags the
// terminal count so the next counter up the chain can be enabled.
module scan_counter
    import vga_timing_pkg::*;
#(
    parameter int MOD = 800
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   en,
    output coord_t cnt,
    output logic   wrap
);

    coord_t cnt_q, cnt_d;

    always_comb begin
        wrap  = (cnt_q == coord_t'(MOD - 1));
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster generator: pixel-rate divider, col/row scan, sync decode and a
// registered output stage that keeps colour and syncs aligned on the pins.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   red_in,
    input  logic   green_in,
    input  logic   blue_in,
    output coord_t col,
    output coord_t row,
    output logic   pix_en,
    output logic   visible,
    output logic   frame_start,
    output logic   VGA_R,
    output logic   VGA_G,
    output logic   VGA_B,
    output logic   VGA_HS,
    output logic   VGA_VS
);

    localparam int H_TOTAL  = seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = sync_start(H_VISIBLE, H_FRONT);
    localparam int HS_END   = sync_end(H_VISIBLE, H_FRONT, H_SYNC);
    localparam int VS_START = sync_start(V_VISIBLE, V_FRONT);
    localparam int VS_END   = sync_end(V_VISIBLE, V_FRONT, V_SYNC);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_en_q, pix_en_d;
    logic [2:0]       rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             hs_raw, vs_raw;
    logic             col_wrap, row_wrap, row_en;

    scan_counter #(.MOD(H_TOTAL)) u_col (
        .CLK  (CLK),
        .RST  (RST),
        .en   (pix_en_q),
        .cnt  (col),
        .wrap (col_wrap)
    );

    assign row_en = pix_en_q && col_wrap;

    scan_counter #(.MOD(V_TOTAL)) u_row (
        .CLK  (CLK),
        .RST  (RST),
        .en   (row_en),
        .cnt  (row),
        .wrap (row_wrap)
    );

    // pix_en is registered from the next divider value so it stays low in reset
    // yet still tracks div_cnt == CLK_DIV-1 (constantly high when CLK_DIV is 1).
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + 1'b1;
        pix_en_d  = (div_cnt_d == DIV_MAX);

        visible = (col < coord_t'(H_VISIBLE)) && (row < coord_t'(V_VISIBLE));
        hs_raw  = !((col >= coord_t'(HS_START)) && (col < coord_t'(HS_END)));
        vs_raw  = !((row >= coord_t'(VS_START)) && (row < coord_t'(VS_END)));

        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (pix_en_q) begin
            rgb_d = visible ? {red_in, green_in, blue_in} : 3'b000;
            hs_d  = hs_raw;
            vs_d  = vs_raw;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
            rgb_q     <= 3'b000;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= pix_en_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign frame_start = pix_en_q && col_wrap && row_wrap;
    assign VGA_R       = rgb_q[2];
    assign VGA_G       = rgb_q[1];
    assign VGA_B       = rgb_q[0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;

endmodule
